// File: rtl/restoring_divider_if.sv
// Handshake and operand/result bundle for the restoring divider.
// The ALU control side is the master; the divider is the slave.
interface restoring_divider_if #(
   parameter int w = 8
);
   logic         start;
   logic [w-1:0] dividend;
   logic [w-1:0] divisor;
   logic         busy;
   logic         done;
   logic [w-1:0] quotient;
   logic [w-1:0] remainder;
   logic         div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/restoring_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// Trial subtraction uses an explicit full-adder chain (x + ~y + 1).
//
//   state | meaning
//   IDLE  | waiting for start
//   RUN   | w trial-subtraction iterations in progress (busy)
//   DONE  | one-cycle done pulse, results just updated; start accepted here too
module restoring_divider #(
   parameter int w = 8
) (
   input  logic               clk,
   input  logic               rst,
   restoring_divider_if.slave bus
);
   localparam int CW = $clog2(w + 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]    state;
   // The top bit of the partial remainder is always zero between iterations:
   // a restore only happens when t < d < 2^w, so only w bits are stored.
   logic [w-1:0]  r;
   logic [w-1:0]  q;
   logic [w-1:0]  d;
   logic [CW-1:0] cnt;
   logic [w-1:0]  quo;
   logic [w-1:0]  rem;
   logic          dbz;

   logic          accept;
   logic          last;
   logic [w:0]    t;
   logic [w:0]    nd;
   logic [w:0]    diff;
   logic [w:0]    c;
   logic [w-1:0]  r_nx;
   logic [w-1:0]  q_nx;

   assign accept = bus.start && (state != RUN);
   assign last   = (cnt == CW'(w - 1));

   // One restoring iteration: shift in the next dividend bit, trial-subtract d.
   always_comb begin
      t    = {r, q[w-1]};
      nd   = ~{1'b0, d};
      c    = '0;
      c[0] = 1'b1;
      for (int i = 0; i < w; i++) begin
         c[i+1] = (t[i] & nd[i]) | (c[i] & (t[i] ^ nd[i]));
      end
      diff = '0;
      for (int i = 0; i <= w; i++) begin
         diff[i] = t[i] ^ nd[i] ^ c[i];
      end
      if (!diff[w]) begin
         r_nx = diff[w-1:0];
         q_nx = {q[w-2:0], 1'b1};
      end else begin
         r_nx = t[w-1:0];
         q_nx = {q[w-2:0], 1'b0};
      end
   end

   // Control state, datapath registers and held results.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         r     <= '0;
         q     <= '0;
         d     <= '0;
         cnt   <= '0;
         quo   <= '0;
         rem   <= '0;
         dbz   <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (accept) begin
                  r   <= '0;
                  q   <= bus.dividend;
                  d   <= bus.divisor;
                  cnt <= '0;
                  if (bus.divisor == '0) begin
                     state <= DONE;
                     quo   <= '1;
                     rem   <= bus.dividend;
                     dbz   <= 1'b1;
                  end else begin
                     state <= RUN;
                  end
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               r   <= r_nx;
               q   <= q_nx;
               cnt <= cnt + CW'(1);
               if (last) begin
                  state <= DONE;
                  quo   <= q_nx;
                  rem   <= r_nx;
                  dbz   <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy        = (state == RUN);
   assign bus.done        = (state == DONE);
   assign bus.quotient    = quo;
   assign bus.remainder   = rem;
   assign bus.div_by_zero = dbz;
endmodule
